// File: rtl/pong_renderer.sv
// pong_renderer: two-stage pixel renderer with per-frame position latch,
// dashed centre net, fixed draw priority and a frame-counted score flash.
module pong_renderer #(
  parameter int         COORD_W       = 10,
  parameter int         BALL_SIZE     = 8,
  parameter int         PADDLE_W      = 8,
  parameter int         PADDLE_H      = 64,
  parameter int         NET_X         = 318,
  parameter int         NET_W         = 4,
  parameter int         NET_DASH_LOG2 = 4,
  parameter int         FLASH_FRAMES  = 30,
  parameter logic [7:0] BG_RGB        = 8'h00,
  parameter logic [7:0] FLASH_RGB     = 8'hE0,
  parameter logic [7:0] BALL_RGB      = 8'hFF,
  parameter logic [7:0] P1_RGB        = 8'h1C,
  parameter logic [7:0] P2_RGB        = 8'h03,
  parameter logic [7:0] NET_RGB       = 8'h92
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic               video_on,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] xpixel,
  input  logic [COORD_W-1:0] ypixel,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddle_one_x,
  input  logic [COORD_W-1:0] paddle_one_y,
  input  logic [COORD_W-1:0] paddle_two_x,
  input  logic [COORD_W-1:0] paddle_two_y,
  input  logic               flash_req,
  output logic [2:0]         red,
  output logic [2:0]         green,
  output logic [1:0]         blue,
  output logic               video_on_q,
  output logic               flashing
);
  localparam int W1 = COORD_W + 1;

  logic [COORD_W-1:0] bx_q, by_q, p1x_q, p1y_q, p2x_q, p2y_q;
  logic [COORD_W-1:0] bx, by, p1x, p1y, p2x, p2y;
  logic               latch;
  logic               ball_h_d, p1_h_d, p2_h_d, net_h_d;
  logic               ball_h_q, p1_h_q, p2_h_q, net_h_q, vid1_q;
  logic [7:0]         rgb_d, rgb_q, cnt_d, cnt_q;

  // Span end computed one bit wider so objects near the top coordinate never wrap.
  function automatic logic in_span(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] o,
                                   input int sz);
    return (p >= o) && ({1'b0, p} < ({1'b0, o} + W1'(sz)));
  endfunction

  assign latch = pix_en && frame_start;
  assign bx    = latch ? ball_x       : bx_q;
  assign by    = latch ? ball_y       : by_q;
  assign p1x   = latch ? paddle_one_x : p1x_q;
  assign p1y   = latch ? paddle_one_y : p1y_q;
  assign p2x   = latch ? paddle_two_x : p2x_q;
  assign p2y   = latch ? paddle_two_y : p2y_q;

  always_comb begin
    ball_h_d = in_span(xpixel, bx, BALL_SIZE) && in_span(ypixel, by, BALL_SIZE);
    p1_h_d   = in_span(xpixel, p1x, PADDLE_W) && in_span(ypixel, p1y, PADDLE_H);
    p2_h_d   = in_span(xpixel, p2x, PADDLE_W) && in_span(ypixel, p2y, PADDLE_H);
    net_h_d  = ({1'b0, xpixel} >= W1'(NET_X)) && ({1'b0, xpixel} < W1'(NET_X + NET_W)) &&
               !ypixel[NET_DASH_LOG2];
    rgb_d    = !vid1_q  ? 8'h00    :
               ball_h_q ? BALL_RGB :
               p1_h_q   ? P1_RGB   :
               p2_h_q   ? P2_RGB   :
               net_h_q  ? NET_RGB  :
               flashing ? FLASH_RGB : BG_RGB;
    cnt_d    = flash_req               ? 8'(FLASH_FRAMES) :
               (latch && cnt_q != '0)  ? cnt_q - 8'd1     : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx_q       <= '0;
      by_q       <= '0;
      p1x_q      <= '0;
      p1y_q      <= '0;
      p2x_q      <= '0;
      p2y_q      <= '0;
      ball_h_q   <= 1'b0;
      p1_h_q     <= 1'b0;
      p2_h_q     <= 1'b0;
      net_h_q    <= 1'b0;
      vid1_q     <= 1'b0;
      rgb_q      <= '0;
      video_on_q <= 1'b0;
      cnt_q      <= '0;
      flashing   <= 1'b0;
    end else begin
      if (latch) begin
        bx_q  <= ball_x;
        by_q  <= ball_y;
        p1x_q <= paddle_one_x;
        p1y_q <= paddle_one_y;
        p2x_q <= paddle_two_x;
        p2y_q <= paddle_two_y;
      end
      if (pix_en) begin
        ball_h_q   <= ball_h_d;
        p1_h_q     <= p1_h_d;
        p2_h_q     <= p2_h_d;
        net_h_q    <= net_h_d;
        vid1_q     <= video_on;
        rgb_q      <= rgb_d;
        video_on_q <= vid1_q;
      end
      cnt_q    <= cnt_d;
      flashing <= cnt_d != '0;
    end
  end

  assign red   = rgb_q[7:5];
  assign green = rgb_q[4:2];
  assign blue  = rgb_q[1:0];
endmodule
